// File: rtl/cnt_mod_updn.sv
// Modulo-(MAX+1) up/down counter with enable, sync clear/load, one-shot stop and cascade tc.
// Define CNT_OVF_STICKY_EN to build the sticky wrap flag; otherwise ovf is tied low.
module cnt_mod_updn #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             done_q;
    logic             wrap;
    logic             at_top, at_bot, terminal;

    // Out-of-range values (only reachable by forcing) count as terminal in either direction.
    assign at_top   = (out_q >= MAX_V);
    assign at_bot   = (out_q == '0) || (out_q > MAX_V);
    assign terminal = up ? at_top : at_bot;

    always_comb begin
        out_d   = out_q;
        state_d = state_q;
        wrap    = 1'b0;
        if (clr) begin
            out_d   = '0;
            state_d = RUN;
        end else if (load) begin
            out_d   = (load_val > MAX_V) ? MAX_V : load_val;
            state_d = RUN;
        end else if (en && state_q == RUN) begin
            if (terminal) begin
                if (mode) begin
                    out_d   = up ? MAX_V : '0;
                    state_d = DONE;
                end else begin
                    out_d = up ? '0 : MAX_V;
                    wrap  = 1'b1;
                end
            end else begin
                out_d = up ? out_q + 1'b1 : out_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= INIT_V;
            state_q <= RUN;
            done_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            state_q <= state_d;
            done_q  <= (state_d == DONE);
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign tc   = en && (state_q == RUN) && terminal;

`ifdef CNT_OVF_STICKY_EN
    logic ovf_q;

    // A clear request beats a wrap landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ovf_q <= 1'b0;
        else if (clr || ovf_clr) ovf_q <= 1'b0;
        else if (wrap)           ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr ^ wrap;
    assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_mod_updn.sv
// Random and directed stimulus for cnt_mod_updn, checked against an integer reference model.
module tb_cnt_mod_updn;
    localparam int WIDTH = 6;
    localparam int MAX   = 59;
    localparam int INIT  = 0;

    logic             clk = 1'b0;
    logic             rst_n, en, up, mode, clr, load, ovf_clr;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tc, done, ovf;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_cnt;
    bit m_done, m_ovf;

    always #10 clk = ~clk;

    cnt_mod_updn #(.WIDTH(WIDTH), .MAX(MAX), .INIT(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .mode(mode), .clr(clr),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .out(out), .tc(tc), .done(done), .ovf(ovf)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit sticky_on();
`ifdef CNT_OVF_STICKY_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_cnt  = INIT;
        m_done = 0;
        m_ovf  = 0;
    endtask

    // one clock: drive at negedge, check tc, apply edge to model, check registered outputs
    task automatic step(input bit e, input bit u, input bit m, input bit c, input bit l,
                        input int lv, input bit oc);
        bit exp_tc;
        @(negedge clk);
        en = e; up = u; mode = m; clr = c; load = l; load_val = WIDTH'(lv); ovf_clr = oc;
        #1;
        exp_tc = e && !m_done && (u ? (m_cnt == MAX) : (m_cnt == 0));
        check("tc", int'(tc), int'(exp_tc));
        if (c) begin
            m_cnt = 0; m_done = 0; m_ovf = 0;
        end else begin
            if (oc) m_ovf = 0;
            if (l) begin
                m_cnt = (lv > MAX) ? MAX : lv;
                m_done = 0;
            end else if (e && !m_done) begin
                if (exp_tc) begin
                    if (m) m_done = 1;
                    else begin
                        m_cnt = u ? 0 : MAX;
                        if (!oc && sticky_on()) m_ovf = 1;
                    end
                end else begin
                    m_cnt = u ? (m_cnt + 1) % (MAX + 1) : (m_cnt + MAX) % (MAX + 1);
                end
            end
        end
        @(posedge clk);
        #1;
        check("out", int'(out), m_cnt);
        check("done", int'(done), int'(m_done));
        check("ovf", int'(ovf), int'(m_ovf));
    endtask

    initial begin
        rst_n = 1'b0; en = 0; up = 0; mode = 0; clr = 0; load = 0; load_val = '0; ovf_clr = 0;
        model_reset();
        #35;
        check("rst_out", int'(out), INIT);
        check("rst_done", int'(done), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_tc", int'(tc), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // free-run up across one full period
        for (int i = 0; i < 60; i++) step(1, 1, 0, 0, 0, 0, 0);
        check("wrap_to_0", int'(out), 0);
        check("ovf_after_wrap", int'(ovf), sticky_on() ? 1 : 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0, 0);
        check("ovf_held", int'(ovf), sticky_on() ? 1 : 0);
        step(0, 1, 0, 0, 0, 0, 1);
        check("ovf_cleared", int'(ovf), 0);

        // load 10, count down through 0 to MAX
        step(0, 0, 0, 0, 1, 10, 0);
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("down_wrap", int'(out), MAX);
        step(0, 0, 0, 0, 1, 63, 0);
        check("load_clamp", int'(out), MAX);

        // one-shot up from 57
        step(0, 1, 1, 0, 1, 57, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0, 0);
        check("oneshot_done", int'(done), 1);
        check("oneshot_hold", int'(out), MAX);
        step(0, 1, 1, 0, 1, 5, 0);
        check("load_exits_done", int'(done), 0);

        // clr beats load; en low holds
        step(0, 1, 0, 0, 1, 30, 0);
        step(1, 1, 0, 1, 1, 20, 0);
        check("clr_wins", int'(out), 0);
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0);

        // same-edge wrap and ovf_clr: clear wins
        step(0, 1, 0, 0, 1, MAX, 0);
        step(1, 1, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) != 0), $urandom_range(1), ($urandom_range(3) == 0),
                 ($urandom_range(31) == 0), ($urandom_range(15) == 0),
                 int'($urandom_range(63)), ($urandom_range(15) == 0));
        end

        // async reset between edges while counting
        step(0, 1, 0, 0, 1, 42, 0);
        @(negedge clk);
        en = 1; up = 1; load = 0; clr = 0; ovf_clr = 0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_out", int'(out), INIT);
        check("arst_done", int'(done), 0);
        check("arst_ovf", int'(ovf), 0);
        en = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // async reset from DONE
        step(0, 1, 1, 0, 1, MAX, 0);
        step(1, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        en = 0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_done_out", int'(out), INIT);
        check("arst_done_flag", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
